kl_word_serializer: RTL and testbench

Parallel-to-serial transmitter for the KL10 diagnostic and scan paths. It accepts a PDP-10 word (bit 0 = MSB) on a valid/ready handshake and shifts it out one bit per `DIV` clocks, framed by a frame strobe. Either end of the word can go first. It is the sending end of the serial links that are received by MC10141-style universal shift-register chains in shift-left or shift-right mode.

---
 rtl/kl_word_serializer.sv | 130 +++++++++++++
 tb/tb_kl_word_serializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/kl_word_serializer.sv
// Word-to-serial transmitter for PDP-10 words (bit 0 = MSB), either end first, DIV clocks per bit.
// Optional odd-parity trailer bit compiled in with `define KL_SER_PARITY_EN.
module kl_word_serializer #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:WIDTH-1] inWord,
  input  logic             inDir,
  input  logic             inValid,
  output logic             inReady,
  output logic             serOut,
  output logic             serFrame,
  output logic             bitStrobe,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

`ifdef KL_SER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StGap, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;
`endif

  state_e           state_q, state_d;
  logic [0:WIDTH-1] sr_q, sr_d;
  logic             dir_q, dir_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [CntW-1:0]  bit_q, bit_d;
  logic             div_zero;
`ifdef KL_SER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign div_zero = (div_q == '0);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    dir_d     = dir_q;
    div_d     = div_q;
    bit_d     = bit_q;
`ifdef KL_SER_PARITY_EN
    par_d     = par_q;
`endif
    inReady   = 1'b0;
    busy      = 1'b1;
    serFrame  = 1'b0;
    serOut    = 1'b0;
    bitStrobe = 1'b0;
    case (state_q)
      StIdle: begin
        inReady = 1'b1;
        busy    = 1'b0;
        if (inValid) begin
          sr_d    = inWord;
          dir_d   = inDir;
          div_d   = DivLast;
          bit_d   = BitLast;
`ifdef KL_SER_PARITY_EN
          par_d   = ~^inWord;
`endif
          state_d = StShift;
        end
      end
      StShift: begin
        serFrame = 1'b1;
        serOut   = dir_q ? sr_q[WIDTH-1] : sr_q[0];
        if (div_zero) begin
          bitStrobe = 1'b1;
          div_d     = DivLast;
          // Shift toward whichever end drives serOut, zero-filling behind.
          sr_d      = dir_q ? {1'b0, sr_q[0:WIDTH-2]} : {sr_q[1:WIDTH-1], 1'b0};
          bit_d     = bit_q - CntW'(1);
          if (bit_q == '0) begin
`ifdef KL_SER_PARITY_EN
            state_d = StParity;
`else
            state_d = StGap;
`endif
          end
        end else begin
          div_d = div_q - DivW'(1);
        end
      end
`ifdef KL_SER_PARITY_EN
      StParity: begin
        serFrame = 1'b1;
        serOut   = par_q;
        if (div_zero) begin
          bitStrobe = 1'b1;
          state_d   = StGap;
        end else begin
          div_d = div_q - DivW'(1);
        end
      end
`endif
      StGap: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      dir_q   <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
`ifdef KL_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
`ifdef KL_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_kl_word_serializer.sv
// Directed bench for kl_word_serializer: one DUT at DIV=4, one at DIV=1, sharing word/dir/reset.
module tb_kl_word_serializer;

`ifdef KL_SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:35] word = '0;
  logic        dir = 1'b0;
  logic        valid = 1'b0;
  logic        sel = 1'b0;
  int          errors = 0;
  int          checks = 0;

  logic a_valid, a_ready, a_out, a_frame, a_strobe, a_busy;
  logic b_valid, b_ready, b_out, b_frame, b_strobe, b_busy;
  logic m_ready, m_out, m_frame, m_strobe, m_busy;

  assign a_valid  = valid & ~sel;
  assign b_valid  = valid & sel;
  assign m_ready  = sel ? b_ready  : a_ready;
  assign m_out    = sel ? b_out    : a_out;
  assign m_frame  = sel ? b_frame  : a_frame;
  assign m_strobe = sel ? b_strobe : a_strobe;
  assign m_busy   = sel ? b_busy   : a_busy;

  kl_word_serializer #(.WIDTH(36), .DIV(4)) dut_a (
    .clk(clk), .reset(reset), .inWord(word), .inDir(dir), .inValid(a_valid),
    .inReady(a_ready), .serOut(a_out), .serFrame(a_frame), .bitStrobe(a_strobe), .busy(a_busy)
  );

  kl_word_serializer #(.WIDTH(36), .DIV(1)) dut_b (
    .clk(clk), .reset(reset), .inWord(word), .inDir(dir), .inValid(b_valid),
    .inReady(b_ready), .serOut(b_out), .serFrame(b_frame), .bitStrobe(b_strobe), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, then record the frame until inReady returns (bounded).
  task automatic run_frame(input logic [0:35] w, input logic d, output int fr, output int st,
                           output int nostb, output int rdy, output logic [0:35] samp,
                           output logic parb);
    fr = 0; st = 0; nostb = 0; rdy = -1; samp = '0; parb = 1'bx;
    word = w; dir = d; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (m_frame) begin
        fr++;
        if (!m_strobe) nostb++;
      end
      if (m_strobe) begin
        if (st < 36) samp[st] = m_out;
        else parb = m_out;
        st++;
      end
      if (m_ready) begin
        rdy = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int stb;
    sel = 1'b0; valid = 1'b0; reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
    checks++; if (a_frame !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", a_frame); end
    checks++; if (a_out !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", a_out); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_b got=%b exp=1", b_ready); end
    stb = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_strobe !== 1'b0 || b_strobe !== 1'b0) stb++;
      tick();
    end
    checks++; if (stb !== 0) begin errors++; $display("FAIL idle_strobe got=%0d exp=0", stb); end
  endtask

  task automatic test_shift_left();
    int fr, st, nostb, rdy;
    logic [0:35] samp;
    logic parb;
    sel = 1'b0;
    run_frame(36'o400000000001, 1'b0, fr, st, nostb, rdy, samp, parb);
    checks++; if (fr !== 144 + 4 * P) begin errors++; $display("FAIL left_frame got=%0d exp=%0d", fr, 144 + 4 * P); end
    checks++; if (st !== 36 + P) begin errors++; $display("FAIL left_strobes got=%0d exp=%0d", st, 36 + P); end
    checks++; if (samp !== 36'o400000000001) begin errors++; $display("FAIL left_bits got=%o exp=400000000001", samp); end
    checks++; if (rdy !== 146 + 4 * P) begin errors++; $display("FAIL left_ready got=%0d exp=%0d", rdy, 146 + 4 * P); end
  endtask

  task automatic test_shift_right_div1();
    int fr, st, nostb, rdy;
    logic [0:35] samp;
    logic parb;
    sel = 1'b1;
    run_frame(36'o000000000003, 1'b1, fr, st, nostb, rdy, samp, parb);
    checks++; if (samp !== 36'hC00000000) begin errors++; $display("FAIL right_bits got=%h exp=c00000000", samp); end
    checks++; if (fr !== 36 + P) begin errors++; $display("FAIL right_frame got=%0d exp=%0d", fr, 36 + P); end
    checks++; if (st !== 36 + P) begin errors++; $display("FAIL right_strobes got=%0d exp=%0d", st, 36 + P); end
    checks++; if (nostb !== 0) begin errors++; $display("FAIL right_nostrobe got=%0d exp=0", nostb); end
    checks++; if (rdy !== 38 + P) begin errors++; $display("FAIL right_ready got=%0d exp=%0d", rdy, 38 + P); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int phase, f1, ones1, gap, ones2, st2;
    phase = 0; f1 = 0; ones1 = 0; gap = 0; ones2 = 0; st2 = 0;
    sel = 1'b0;
    word = 36'o777777777777; dir = 1'b0; valid = 1'b1;
    tick();
    word = '0;
    for (int k = 0; k < 800; k++) begin
      if (phase == 0) begin
        if (m_frame) begin
          f1++;
          if (m_strobe && m_out) ones1++;
        end else begin
          phase = 1; gap = 1;
        end
      end else if (phase == 1) begin
        if (!m_frame) gap++;
        else begin
          phase = 2; valid = 1'b0;
        end
      end
      if (phase == 2) begin
        if (!m_frame) begin
          phase = 3;
          break;
        end
        if (m_strobe) begin
          st2++;
          if (m_out) ones2++;
        end
      end
      tick();
    end
    valid = 1'b0;
    checks++; if (phase !== 3) begin errors++; $display("FAIL b2b_done got=%0d exp=3", phase); end
    checks++; if (f1 !== 144 + 4 * P) begin errors++; $display("FAIL b2b_frame1 got=%0d exp=%0d", f1, 144 + 4 * P); end
    checks++; if (ones1 !== 36 + P) begin errors++; $display("FAIL b2b_ones1 got=%0d exp=%0d", ones1, 36 + P); end
    // Low stretch is the GAP cycle plus the IDLE cycle in which the next word is taken.
    checks++; if (gap !== 2) begin errors++; $display("FAIL b2b_gap got=%0d exp=2", gap); end
    checks++; if (ones2 !== P) begin errors++; $display("FAIL b2b_ones2 got=%0d exp=%0d", ones2, P); end
    checks++; if (st2 !== 36 + P) begin errors++; $display("FAIL b2b_strobes2 got=%0d exp=%0d", st2, 36 + P); end
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_frame();
    int st, fr, nostb, rdy;
    logic [0:35] samp;
    logic parb;
    sel = 1'b0; st = 0;
    word = 36'o777777777777; dir = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 200 && st < 10; k++) begin
      if (m_strobe) st++;
      tick();
    end
    checks++; if (m_frame !== 1'b1) begin errors++; $display("FAIL mid_inframe got=%b exp=1", m_frame); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (m_frame !== 1'b0) begin errors++; $display("FAIL mid_frame got=%b exp=0", m_frame); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", m_ready); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", m_busy); end
    run_frame(36'o123456701234, 1'b0, fr, st, nostb, rdy, samp, parb);
    checks++; if (samp !== 36'o123456701234) begin errors++; $display("FAIL mid_bits got=%o exp=123456701234", samp); end
    checks++; if (fr !== 144 + 4 * P) begin errors++; $display("FAIL mid_newframe got=%0d exp=%0d", fr, 144 + 4 * P); end
  endtask

`ifdef KL_SER_PARITY_EN
  task automatic test_parity();
    int fr, st, nostb, rdy;
    logic [0:35] samp;
    logic parb;
    sel = 1'b0;
    run_frame(36'o0, 1'b0, fr, st, nostb, rdy, samp, parb);
    checks++; if (parb !== 1'b1) begin errors++; $display("FAIL par0_bit got=%b exp=1", parb); end
    checks++; if (fr !== 148) begin errors++; $display("FAIL par0_frame got=%0d exp=148", fr); end
    run_frame(36'o1, 1'b0, fr, st, nostb, rdy, samp, parb);
    checks++; if (parb !== 1'b0) begin errors++; $display("FAIL par1_bit got=%b exp=0", parb); end
    checks++; if (st !== 37) begin errors++; $display("FAIL par1_strobes got=%0d exp=37", st); end
  endtask
`endif

  initial begin
    test_reset();
    test_shift_left();
    test_shift_right_div1();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef KL_SER_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
